// File: rtl/csr_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_regs_pkg
// Brief    : Address map, bad-read value and word type for the CSR register bank.
// Revision : 1.0 - initial release
// ============================================================================
package csr_regs_pkg;

    typedef logic [31:0] csr_word_t;

    localparam logic [15:0] CSR_ADDR_ID          = 16'h0000;
    localparam logic [15:0] CSR_ADDR_CONTROL     = 16'h0004;
    localparam logic [15:0] CSR_ADDR_STATUS      = 16'h0008;
    localparam logic [15:0] CSR_ADDR_IRQ_ENABLE  = 16'h000C;
    localparam logic [15:0] CSR_ADDR_SCRATCH     = 16'h0010;
    localparam logic [15:0] CSR_ADDR_EVENT_COUNT = 16'h0014;
    localparam logic [15:0] CSR_ADDR_TS_LO       = 16'h0018;
    localparam logic [15:0] CSR_ADDR_TS_HI       = 16'h001C;

    localparam csr_word_t CSR_BAD_VALUE = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/csr_timestamp.sv
`default_nettype none
// ============================================================================
// Module   : csr_timestamp
// Brief    : Free-running 64-bit cycle counter with an upper-word shadow that is
//            captured whenever the low word is read.
// Revision : 1.0 - initial release
// ============================================================================
module csr_timestamp
    import csr_regs_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      i_latch_hi,
    output csr_word_t o_count_lo,
    output csr_word_t o_shadow
);

    logic [63:0] r_count;
    csr_word_t   r_shadow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            r_count <= r_count + 64'd1;
            // Capturing the high word alongside the low-word read gives a coherent 64-bit pair.
            if (i_latch_hi) begin
                r_shadow <= r_count[63:32];
            end
        end
    end

    assign o_count_lo = r_count[31:0];
    assign o_shadow   = r_shadow;

endmodule
`default_nettype wire

// File: rtl/csr_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_register_bank
// Brief    : CSR responder: ID, CONTROL, W1C STATUS, IRQ_ENABLE, SCRATCH and a
//            saturating EVENT_COUNT. Define CSR_TIMESTAMP_EN to add TS_LO/TS_HI.
// Revision : 1.0 - initial release
// ============================================================================
module csr_register_bank
    import csr_regs_pkg::*;
#(
    parameter int unsigned CSR_DATA_WIDTH    = 32,
    parameter int unsigned CSR_ADDRESS_WIDTH = 16,
    parameter int unsigned NUM_EVENTS        = 8,
    parameter csr_word_t   ID_VALUE          = 32'hA0F6_0001,
    parameter csr_word_t   CTRL_RESET        = 32'h0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         CSR_write_enable,
    input  logic [CSR_DATA_WIDTH-1:0]    CSR_write_data,
    input  logic [CSR_ADDRESS_WIDTH-1:0] CSR_write_address,
    input  logic                         CSR_read_enable,
    output logic [CSR_DATA_WIDTH-1:0]    CSR_read_data,
    input  logic [CSR_ADDRESS_WIDTH-1:0] CSR_read_address,
    input  logic [NUM_EVENTS-1:0]        event_pulse,
    output logic [CSR_DATA_WIDTH-1:0]    control,
    output logic                         irq
);

    if (CSR_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("csr_register_bank: CSR_DATA_WIDTH must be 32");
    end
    if (NUM_EVENTS < 1 || NUM_EVENTS > 32) begin : g_bad_num_events
        $error("csr_register_bank: NUM_EVENTS must be in 1..32");
    end

    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_id    = CSR_ADDRESS_WIDTH'(CSR_ADDR_ID);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_ctrl  = CSR_ADDRESS_WIDTH'(CSR_ADDR_CONTROL);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_stat  = CSR_ADDRESS_WIDTH'(CSR_ADDR_STATUS);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_irqen = CSR_ADDRESS_WIDTH'(CSR_ADDR_IRQ_ENABLE);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_scr   = CSR_ADDRESS_WIDTH'(CSR_ADDR_SCRATCH);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_evcnt = CSR_ADDRESS_WIDTH'(CSR_ADDR_EVENT_COUNT);

    logic [CSR_ADDRESS_WIDTH-1:0] w_wr_addr;
    logic [CSR_ADDRESS_WIDTH-1:0] w_rd_addr;
    logic                         w_unused_addr_bits;

    // Byte offsets within a word are ignored on both ports.
    assign w_wr_addr          = {CSR_write_address[CSR_ADDRESS_WIDTH-1:2], 2'b00};
    assign w_rd_addr          = {CSR_read_address[CSR_ADDRESS_WIDTH-1:2], 2'b00};
    assign w_unused_addr_bits = ^{CSR_write_address[1:0], CSR_read_address[1:0]};

    logic w_wr_ctrl, w_wr_stat, w_wr_irqen, w_wr_scr, w_wr_evcnt;

    assign w_wr_ctrl  = CSR_write_enable && (w_wr_addr == c_addr_ctrl);
    assign w_wr_stat  = CSR_write_enable && (w_wr_addr == c_addr_stat);
    assign w_wr_irqen = CSR_write_enable && (w_wr_addr == c_addr_irqen);
    assign w_wr_scr   = CSR_write_enable && (w_wr_addr == c_addr_scr);
    assign w_wr_evcnt = CSR_write_enable && (w_wr_addr == c_addr_evcnt);

    csr_word_t             r_control;
    logic [NUM_EVENTS-1:0] r_status;
    logic [NUM_EVENTS-1:0] r_irq_en;
    csr_word_t             r_scratch;
    csr_word_t             r_event_count;
    csr_word_t             r_read_data;
    logic                  r_irq;

    logic [NUM_EVENTS-1:0] w_status_clr;
    logic [NUM_EVENTS-1:0] w_status_next;
    logic                  w_any_event;
    csr_word_t             w_event_count_next;

    assign w_status_clr  = w_wr_stat ? CSR_write_data[NUM_EVENTS-1:0] : '0;
    // Set is applied after clear so a same-cycle event is never lost.
    assign w_status_next = (r_status & ~w_status_clr) | event_pulse;
    assign w_any_event   = |event_pulse;

    always_comb begin
        w_event_count_next = r_event_count;
        if (w_wr_evcnt) begin
            w_event_count_next = w_any_event ? 32'd1 : 32'd0;
        end else if (w_any_event && (r_event_count != 32'hFFFF_FFFF)) begin
            w_event_count_next = r_event_count + 32'd1;
        end
    end

`ifdef CSR_TIMESTAMP_EN
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_ts_lo = CSR_ADDRESS_WIDTH'(CSR_ADDR_TS_LO);
    localparam logic [CSR_ADDRESS_WIDTH-1:0] c_addr_ts_hi = CSR_ADDRESS_WIDTH'(CSR_ADDR_TS_HI);

    csr_word_t w_ts_lo;
    csr_word_t w_ts_hi;

    csr_timestamp u_timestamp (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_latch_hi (CSR_read_enable && (w_rd_addr == c_addr_ts_lo)),
        .o_count_lo (w_ts_lo),
        .o_shadow   (w_ts_hi)
    );
`endif

    csr_word_t w_status_word;
    csr_word_t w_irq_en_word;
    csr_word_t w_rd_word;

    always_comb begin
        w_status_word                 = '0;
        w_status_word[NUM_EVENTS-1:0] = r_status;
        w_irq_en_word                 = '0;
        w_irq_en_word[NUM_EVENTS-1:0] = r_irq_en;
        case (w_rd_addr)
            c_addr_id:    w_rd_word = ID_VALUE;
            c_addr_ctrl:  w_rd_word = r_control;
            c_addr_stat:  w_rd_word = w_status_word;
            c_addr_irqen: w_rd_word = w_irq_en_word;
            c_addr_scr:   w_rd_word = r_scratch;
            c_addr_evcnt: w_rd_word = r_event_count;
`ifdef CSR_TIMESTAMP_EN
            c_addr_ts_lo: w_rd_word = w_ts_lo;
            c_addr_ts_hi: w_rd_word = w_ts_hi;
`endif
            default:      w_rd_word = CSR_BAD_VALUE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_control     <= CTRL_RESET;
            r_status      <= '0;
            r_irq_en      <= '0;
            r_scratch     <= '0;
            r_event_count <= '0;
            r_read_data   <= '0;
            r_irq         <= 1'b0;
        end else begin
            if (w_wr_ctrl)  r_control <= CSR_write_data;
            if (w_wr_irqen) r_irq_en  <= CSR_write_data[NUM_EVENTS-1:0];
            if (w_wr_scr)   r_scratch <= CSR_write_data;
            r_status      <= w_status_next;
            r_event_count <= w_event_count_next;
            if (CSR_read_enable) r_read_data <= w_rd_word;
            r_irq <= |(r_status & r_irq_en);
        end
    end

    assign CSR_read_data = r_read_data;
    assign control       = r_control;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_csr_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_register_bank
// Brief    : Directed self-checking bench for csr_register_bank (either
//            CSR_TIMESTAMP_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_register_bank;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        CSR_write_enable;
    logic [31:0] CSR_write_data;
    logic [15:0] CSR_write_address;
    logic        CSR_read_enable;
    logic [31:0] CSR_read_data;
    logic [15:0] CSR_read_address;
    logic [7:0]  event_pulse;
    logic [31:0] control;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    csr_register_bank dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .CSR_write_enable  (CSR_write_enable),
        .CSR_write_data    (CSR_write_data),
        .CSR_write_address (CSR_write_address),
        .CSR_read_enable   (CSR_read_enable),
        .CSR_read_data     (CSR_read_data),
        .CSR_read_address  (CSR_read_address),
        .event_pulse       (event_pulse),
        .control           (control),
        .irq               (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clock);
        CSR_write_enable  = 1'b1;
        CSR_write_address = a;
        CSR_write_data    = d;
        @(negedge clock);
        CSR_write_enable  = 1'b0;
    endtask

    task automatic csr_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clock);
        CSR_read_enable  = 1'b1;
        CSR_read_address = a;
        @(negedge clock);
        CSR_read_enable  = 1'b0;
        d = CSR_read_data;
    endtask

    task automatic csr_rw(input logic [15:0] ra, input logic [15:0] wa,
                          input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clock);
        CSR_read_enable   = 1'b1;
        CSR_read_address  = ra;
        CSR_write_enable  = 1'b1;
        CSR_write_address = wa;
        CSR_write_data    = wd;
        @(negedge clock);
        CSR_read_enable  = 1'b0;
        CSR_write_enable = 1'b0;
        rd = CSR_read_data;
    endtask

    initial begin
        logic [31:0] rd;

        reset_n           = 1'b0;
        CSR_write_enable  = 1'b0;
        CSR_write_data    = '0;
        CSR_write_address = '0;
        CSR_read_enable   = 1'b0;
        CSR_read_address  = '0;
        event_pulse       = '0;
        repeat (3) @(negedge clock);
        check("reset_read_data", CSR_read_data, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_control", control, 32'h0);
        reset_n = 1'b1;

        // Register map after reset
        csr_read(16'h0000, rd); check("id", rd, 32'hA0F6_0001);
        csr_read(16'h0004, rd); check("control_reset", rd, 32'h0);
        csr_read(16'h0008, rd); check("status_reset", rd, 32'h0);
        check("irq_after_reset", {31'd0, irq}, 32'h0);
        csr_read(16'h0007, rd); check("byte_offset_ignored", rd, 32'h0);

        // Same-cycle read returns the pre-write value
        csr_rw(16'h0010, 16'h0010, 32'h1234_5678, rd); check("scratch_rw_same_cycle", rd, 32'h0);
        csr_read(16'h0010, rd); check("scratch_readback", rd, 32'h1234_5678);
        csr_write(16'h0004, 32'hCAFE_0001);
        check("control_port_after_write", control, 32'hCAFE_0001);
        csr_read(16'h0004, rd); check("control_readback", rd, 32'hCAFE_0001);

        // Events, IRQ enable masking and W1C
        @(negedge clock); event_pulse = 8'h05;
        @(negedge clock); event_pulse = 8'h00;
        csr_write(16'h000C, 32'hFFFF_FF01);
        check("irq_lags_enable", {31'd0, irq}, 32'h0);
        csr_read(16'h0008, rd); check("status_events", rd, 32'h5);
        check("irq_asserted", {31'd0, irq}, 32'h1);
        csr_read(16'h0014, rd); check("event_count_one", rd, 32'h1);
        csr_read(16'h000C, rd); check("irq_enable_masked", rd, 32'h1);
        csr_write(16'h0008, 32'h1);
        csr_read(16'h0008, rd); check("status_w1c", rd, 32'h4);
        check("irq_deasserted", {31'd0, irq}, 32'h0);
        csr_write(16'h0014, 32'h5555_5555);
        csr_read(16'h0014, rd); check("event_count_cleared", rd, 32'h0);

        // Set wins over W1C; clear plus increment gives 1
        @(negedge clock);
        event_pulse       = 8'h01;
        CSR_write_enable  = 1'b1;
        CSR_write_address = 16'h0008;
        CSR_write_data    = 32'h1;
        @(negedge clock);
        CSR_write_address = 16'h0014;
        CSR_write_data    = 32'h0;
        @(negedge clock);
        event_pulse      = 8'h00;
        CSR_write_enable = 1'b0;
        csr_read(16'h0008, rd); check("status_set_wins", rd, 32'h5);
        csr_read(16'h0014, rd); check("event_clear_and_inc", rd, 32'h1);

        // Saturation of EVENT_COUNT
        @(negedge clock);
        force dut.r_event_count = 32'hFFFF_FFFE;
        event_pulse = 8'h80;
        repeat (2) @(negedge clock);
        release dut.r_event_count;
        repeat (3) @(negedge clock);
        event_pulse = 8'h00;
        csr_read(16'h0014, rd); check("event_count_saturates", rd, 32'hFFFF_FFFF);

        // Unmapped read with a write to the read-only ID
        csr_rw(16'h003C, 16'h0000, 32'h0, rd); check("unmapped_read", rd, 32'hDEAD_BEEF);
        csr_read(16'h0000, rd); check("id_unchanged", rd, 32'hA0F6_0001);
        csr_read(16'h0020, rd); check("unmapped_0x20", rd, 32'hDEAD_BEEF);

`ifdef CSR_TIMESTAMP_EN
        @(negedge clock);
        force dut.u_timestamp.r_count = 64'h0000_0001_FFFF_FFFF;
        CSR_read_enable  = 1'b1;
        CSR_read_address = 16'h0018;
        @(negedge clock);
        release dut.u_timestamp.r_count;
        CSR_read_enable = 1'b0;
        check("ts_lo", CSR_read_data, 32'hFFFF_FFFF);
        repeat (2) @(negedge clock);
        csr_read(16'h001C, rd); check("ts_hi_shadow", rd, 32'h1);
`else
        csr_read(16'h0018, rd); check("ts_lo_unmapped", rd, 32'hDEAD_BEEF);
        csr_read(16'h001C, rd); check("ts_hi_unmapped", rd, 32'hDEAD_BEEF);
`endif

        // Asynchronous reset in the middle of a write burst
        csr_read(16'h0010, rd); check("scratch_before_reset", rd, 32'h1234_5678);
        check("irq_before_reset", {31'd0, irq}, 32'h1);
        @(negedge clock);
        CSR_write_enable  = 1'b1;
        CSR_write_address = 16'h0010;
        CSR_write_data    = 32'h0BAD_F00D;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_read_data", CSR_read_data, 32'h0);
        check("async_reset_irq", {31'd0, irq}, 32'h0);
        check("async_reset_control", control, 32'h0);
        @(negedge clock);
        CSR_write_enable = 1'b0;
        reset_n = 1'b1;
        csr_read(16'h0010, rd); check("scratch_after_reset", rd, 32'h0);
        csr_read(16'h0008, rd); check("status_after_reset", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
